// File: rtl/irq_controller_if.sv
// CPU-side register bus for the interrupt controller: select/byte-enable/read
// strobe/word address in, combinational read data out.
interface irq_controller_if;
  logic        select;
  logic [3:0]  wr;
  logic        rd;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output select,
    output wr,
    output rd,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  select,
    input  wr,
    input  rd,
    input  addr,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt aggregator: per-source edge/level latching, masking, W1C acknowledge,
// lowest-index priority cause, and a registered global interrupt request.
module irq_controller #(
  parameter int          NSRC         = 8,
  parameter logic [15:0] EDGE_MASK    = 16'h0000,
  parameter logic [15:0] RESET_ENABLE = 16'h0000
) (
  input  logic            clk,
  input  logic            reset,
  irq_controller_if.slave bus,
  input  logic [NSRC-1:0] src,
  output logic            interrupt
);

  localparam logic [1:0] ADDR_RAW    = 2'd0;
  localparam logic [1:0] ADDR_PEND   = 2'd1;
  localparam logic [1:0] ADDR_ENABLE = 2'd2;
  localparam logic [1:0] ADDR_CAUSE  = 2'd3;

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] en;
  logic            gie;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend_clr;
  logic [NSRC-1:0] pend_nxt;
  logic [NSRC-1:0] en_wmask;
  logic [NSRC-1:0] active;
  logic [31:0]     lane_mask;
  logic [31:0]     wdata;
  logic            wr_any;
  logic            wr_pend;
  logic            wr_enable;
  logic            cause_vld;
  logic [3:0]      cause_idx;
  logic            unused_bus;

  function automatic logic [31:0] expand_lanes(input logic [3:0] be);
    expand_lanes = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] zext_src(input logic [NSRC-1:0] v);
    zext_src = '0;
    zext_src[NSRC-1:0] = v;
  endfunction

  // Write decode: byte lanes gate data; bits at or above NSRC never reach state.
  assign wr_any    = bus.select & (|bus.wr);
  assign wr_pend   = wr_any & (bus.addr == ADDR_PEND);
  assign wr_enable = wr_any & (bus.addr == ADDR_ENABLE);
  assign lane_mask = expand_lanes(bus.wr);
  assign wdata     = bus.data_in & lane_mask;
  assign pend_clr  = wr_pend ? wdata[NSRC-1:0] : '0;
  assign en_wmask  = lane_mask[NSRC-1:0];

  assign rise   = src & ~src_q;
  assign active = pend & en;

  // Edge sources: set beats clear so an edge coincident with an ack is kept.
  // Level sources simply track the line; their ack lives in the peripheral.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (EDGE_MASK[i]) begin
        pend_nxt[i] = rise[i] | (pend[i] & ~pend_clr[i]);
      end else begin
        pend_nxt[i] = src[i];
      end
    end
  end

  // Stage boundary: source history, pending, enable and request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q     <= '0;
      pend      <= '0;
      en        <= RESET_ENABLE[NSRC-1:0];
      gie       <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      src_q     <= src;
      pend      <= pend_nxt;
      interrupt <= gie & (|active);
      if (wr_enable) begin
        en <= (en & ~en_wmask) | (wdata[NSRC-1:0] & en_wmask);
        if (bus.wr[3]) begin
          gie <= wdata[31];
        end
      end
    end
  end

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    cause_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        cause_idx = 4'(i);
      end
    end
  end

  assign cause_vld = |active;

  always_comb begin
    bus.data_out = '0;
    case (bus.addr)
      ADDR_RAW:    bus.data_out = zext_src(src);
      ADDR_PEND:   bus.data_out = zext_src(pend);
      ADDR_ENABLE: begin
        bus.data_out     = zext_src(en);
        bus.data_out[31] = gie;
      end
      ADDR_CAUSE:  bus.data_out = {cause_vld, 27'd0, cause_idx};
      default:     bus.data_out = '0;
    endcase
  end

  // Read strobe has no side effects; upper write-data bits are don't-care.
  assign unused_bus = &{1'b0, bus.rd, wdata, lane_mask};

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: directed bus traffic pushes expected
// read data / request level; a negedge monitor pops and compares on each read.
module tb_irq_controller;

  localparam int NSRC = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src;
  logic            interrupt;

  irq_controller_if bus ();

  irq_controller #(
    .NSRC         (NSRC),
    .EDGE_MASK    (16'h0019),
    .RESET_ENABLE (16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .src       (src),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    bit          chk_irq;
    logic        irq;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [1:0] A_RAW = 2'd0, A_PEND = 2'd1, A_EN = 2'd2, A_CAUSE = 2'd3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.select  = 1'b1;
    bus.wr      = be;
    bus.addr    = a;
    bus.data_in = d;
    tick();
    bus.select  = 1'b0;
    bus.wr      = 4'h0;
    bus.data_in = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input bit ci,
                          input logic ei, input string nm);
    exp_t x;
    x.name    = nm;
    x.data    = e;
    x.chk_irq = ci;
    x.irq     = ei;
    sbq.push_back(x);
    bus.select = 1'b1;
    bus.rd     = 1'b1;
    bus.addr   = a;
    tick();
    bus.select = 1'b0;
    bus.rd     = 1'b0;
  endtask

  // Monitor: every read strobe presents data_out (and optionally the request).
  always @(negedge clk) begin
    if (bus.rd === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: got data_out=%08h, required no read", bus.data_out);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        n_cmp++;
        if (bus.data_out !== x.data) begin
          n_bad++;
          $display("FAIL %s data: got %08h, required %08h", x.name, bus.data_out, x.data);
        end
        if (x.chk_irq) begin
          n_cmp++;
          if (interrupt !== x.irq) begin
            n_bad++;
            $display("FAIL %s interrupt: got %b, required %b", x.name, interrupt, x.irq);
          end
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    src         = '0;
    bus.select  = 1'b0;
    bus.wr      = 4'h0;
    bus.rd      = 1'b0;
    bus.addr    = 2'd0;
    bus.data_in = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Reset state
    bus_read(A_RAW,   32'h0000_0000, 1, 1'b0, "rst_raw");
    bus_read(A_PEND,  32'h0000_0000, 1, 1'b0, "rst_pend");
    bus_read(A_EN,    32'h0000_0000, 1, 1'b0, "rst_enable");
    bus_read(A_CAUSE, 32'h0000_0000, 1, 1'b0, "rst_cause");

    // Edge source 3: latch, request two clocks after the edge, W1C ack
    bus_write(A_EN, 32'h8000_0008, 4'hF);
    src = 8'h08;
    tick();
    src = 8'h00;
    bus_read(A_PEND,  32'h0000_0008, 1, 1'b0, "edge3_pend");
    bus_read(A_CAUSE, 32'h8000_0003, 1, 1'b1, "edge3_cause");
    bus_write(A_PEND, 32'h0000_0008, 4'hF);
    bus_read(A_PEND,  32'h0000_0000, 0, 1'b0, "edge3_ack_pend");
    bus_read(A_CAUSE, 32'h0000_0000, 1, 1'b0, "edge3_ack_cause");

    // Held edge source latches once; re-arm needs a low cycle
    src = 8'h08;
    tick();
    bus_write(A_PEND, 32'h0000_0008, 4'hF);
    bus_read(A_PEND,  32'h0000_0000, 0, 1'b0, "held_no_rearm");
    src = 8'h00;
    tick();
    src = 8'h08;
    tick();
    bus_read(A_PEND,  32'h0000_0008, 0, 1'b0, "held_rearm");
    src = 8'h00;
    bus_write(A_PEND, 32'h0000_0008, 4'hF);

    // Level source 1: follows line, W1C and RAW writes ignored
    bus_write(A_EN, 32'h8000_0002, 4'hF);
    src = 8'h02;
    tick();
    bus_write(A_RAW,  32'hFFFF_FFFF, 4'hF);
    bus_write(A_PEND, 32'h0000_0002, 4'hF);
    bus_read(A_PEND,  32'h0000_0002, 1, 1'b1, "level1_w1c_ignored");
    bus_read(A_RAW,   32'h0000_0002, 1, 1'b1, "level1_raw");
    src = 8'h00;
    tick();
    bus_read(A_CAUSE, 32'h0000_0000, 1, 1'b1, "level1_drop_1clk");
    bus_read(A_CAUSE, 32'h0000_0000, 1, 1'b0, "level1_drop_2clk");

    // Edge and W1C in the same cycle: set wins
    src = 8'h01;
    bus_write(A_PEND, 32'h0000_0001, 4'hF);
    src = 8'h00;
    bus_read(A_PEND,  32'h0000_0001, 1, 1'b0, "edge_vs_clear");
    bus_write(A_PEND, 32'h0000_0001, 4'hF);
    bus_read(A_PEND,  32'h0000_0000, 0, 1'b0, "edge0_cleared");

    // Priority: 3 beats 4; CAUSE survives GIE off
    bus_write(A_EN, 32'h8000_0018, 4'hF);
    src = 8'h18;
    tick();
    src = 8'h00;
    bus_read(A_CAUSE, 32'h8000_0003, 0, 1'b0, "prio_3_over_4");
    bus_write(A_PEND, 32'h0000_0008, 4'hF);
    bus_read(A_CAUSE, 32'h8000_0004, 1, 1'b1, "prio_4_after_clr3");
    bus_write(A_EN, 32'h0000_0018, 4'hF);
    bus_read(A_CAUSE, 32'h8000_0004, 0, 1'b0, "gie_off_cause_1clk");
    bus_read(A_CAUSE, 32'h8000_0004, 1, 1'b0, "gie_off_cause_valid");
    bus_write(A_PEND, 32'h0000_00FF, 4'hF);
    bus_read(A_PEND,  32'h0000_0000, 0, 1'b0, "pend_all_cleared");

    // Byte lanes and unimplemented enable bits
    bus_write(A_EN, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_EN,    32'h8000_00FF, 0, 1'b0, "enable_upper_zero");
    bus_write(A_EN, 32'h0000_0000, 4'b0001);
    bus_read(A_EN,    32'h8000_0000, 0, 1'b0, "enable_lane0_only");
    bus_write(A_EN, 32'h0000_0000, 4'b1000);
    bus_read(A_EN,    32'h0000_0000, 0, 1'b0, "enable_lane3_gie");

    // Masked latch, late enable, then asynchronous reset while pending
    bus_write(A_EN, 32'h8000_0000, 4'hF);
    src = 8'h08;
    tick();
    src = 8'h00;
    bus_read(A_PEND,  32'h0000_0008, 1, 1'b0, "masked_latch");
    bus_read(A_PEND,  32'h0000_0008, 1, 1'b0, "masked_hold");
    bus_write(A_EN, 32'h8000_0008, 4'hF);
    bus_read(A_PEND,  32'h0000_0008, 0, 1'b0, "late_enable_0");
    bus_read(A_PEND,  32'h0000_0008, 1, 1'b1, "late_enable_irq");
    reset = 1'b1;
    bus_read(A_PEND,  32'h0000_0000, 1, 1'b0, "async_rst_pend");
    bus_read(A_EN,    32'h0000_0000, 1, 1'b0, "async_rst_enable");
    bus_read(A_CAUSE, 32'h0000_0000, 0, 1'b0, "async_rst_cause");
    reset = 1'b0;
    tick();
    bus_read(A_PEND,  32'h0000_0000, 1, 1'b0, "post_rst_pend");

    repeat (3) tick();
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Aggregates the SoC peripheral interrupt sources into the single CPU `interrupt_request` line: general timer, UART rx valid, econet rx frame valid, econet timer A, SD card detect, and spare sources.
- Sits directly downstream of the peripherals and upstream of FemtoRV32.
- Replaces the plain OR of source lines with per-source edge latching, masking, write-1-to-clear acknowledge and a priority cause register.
- Memory-mapped as a 4-word register block on the CPU bus.

Parameters:
- `NSRC`, 8: number of interrupt sources, 1..16.
- `EDGE_MASK`, 8'h00: per-source mode. 1 = rising-edge latched; 0 = level, pending follows the source.
- `RESET_ENABLE`, 8'h00: ENABLE[NSRC-1:0] value after reset.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `select`, input, 1: register block selected, decoded upstream.
- `wr`, input, 4: CPU byte write enables (`mem_wmask`).
- `rd`, input, 1: CPU read strobe (`mem_rstrb`).
- `addr`, input, 2: word address, `mem_addr[3:2]`.
- `data_in`, input, 32: CPU write data.
- `data_out`, output, 32: register read data, combinational from `addr`.
- `src`, input, NSRC: interrupt source lines, active-high, synchronous to `clk`.
- `interrupt`, output, 1: registered interrupt request to the CPU.

Behaviour:
- One clock domain and one reset: `clk`, and asynchronous active-high `reset`.
- Reset values:
  - `src_q` = 0.
  - PENDING = 0.
  - ENABLE = `RESET_ENABLE`; global enable GIE (ENABLE[31]) = 0.
  - `interrupt` = 0.
  - `data_out` reflects reset register values.
- Register map (`addr`):
  - 0, RAW (read-only): {0, `src`}. Writes are ignored.
  - 1, PENDING (read; write-1-to-clear): {0, `pend`}.
  - 2, ENABLE (read/write): {GIE, 0, `en[NSRC-1:0]`}.
  - 3, CAUSE (read-only): {valid at bit 31, 0, index at [3:0]}.
- Writes are byte-lane qualified by `wr[i]` for `data_in` bits [8i+7:8i]. A write occurs when `select` is set and `wr` is nonzero. `rd` has no side effects.
- Edge sources (`EDGE_MASK[i]` = 1):
  - `src_q` registers `src` every cycle; a rising edge is `src & ~src_q`.
  - A rising edge sets `pend[i]` on the next clk.
  - A PENDING write with `data_in[i]` = 1 (lane enabled) clears `pend[i]`.
  - Edge and clear in the same cycle: set wins, so no event is lost.
  - A source held high sets `pend[i]` only once; re-arm requires a low cycle.
- Level sources (`EDGE_MASK[i]` = 0):
  - `pend[i]` = `src[i]`, registered one cycle.
  - W1C writes have no effect; the acknowledge goes to the source peripheral.
- Latching is independent of `en[i]`. A masked edge source still latches pending, so enabling it later raises the IRQ.
- `active` = `pend & en`.
- `interrupt` is registered: next value = GIE & |`active`.
  - Source edge to `interrupt` high: 2 clk for edge sources, 2 clk for level sources.
  - Interrupt deasserts 1 clk after the W1C or disable write.
- CAUSE:
  - Combinational priority encode of `active`: lowest index wins.
  - valid = |`active`; index = 0 when not valid.
  - CAUSE is independent of GIE, so software can poll with GIE off.
- PENDING read value is pre-update: a read in the same cycle as a write returns the old value.
- Bits at or above NSRC read as 0 and are ignored on write.
- `reset` asserted mid-operation clears pending and `interrupt` immediately (asynchronous), with no glitch requirement on `data_out`.
- Standard SoC assignment:
  - src[0] general timer.
  - src[1] UART valid, level.
  - src[2] econet rx valid, level.
  - src[3] econet timer A.
  - src[4] SD card detect.
  - Remaining sources spare.

Test Plan:
- Reset, then read all registers → RAW = 0, PENDING = 0, ENABLE = `RESET_ENABLE` (0x00000000), CAUSE = 0, `interrupt` = 0.
- `EDGE_MASK` = 8'h19. Pulse src[3] for 1 clk with ENABLE = 0x80000008 → PENDING = 0x08 after 1 clk, `interrupt` = 1 after 2 clk, CAUSE = 0x80000003. Write PENDING = 0x08 → `interrupt` = 0 one clk later, PENDING = 0.
- Hold src[1] (level) high with ENABLE = 0x80000002 → `interrupt` stays 1 while held; writing PENDING = 0x02 has no effect; dropping src[1] clears `interrupt` 2 clk later.
- Edge on src[0] in the same cycle as a W1C of bit 0 → PENDING[0] = 1 afterwards.
- src[4] and src[3] both pending, both enabled → CAUSE index = 3; clear bit 3 → CAUSE = 0x80000004. GIE = 0 → `interrupt` = 0 while CAUSE stays valid.
- src[3] pulsed while ENABLE[3] = 0 → `interrupt` = 0, PENDING = 0x08; write ENABLE = 0x80000008 → `interrupt` = 1 next clk. Assert `reset` mid-pending → PENDING = 0 and `interrupt` = 0 immediately.
